// File: rtl/dbg_cmd_pkg.sv
// Shared types and constants for the host-debug command sequencer.
package dbg_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_GRAB,
        S_ACCESS,
        S_TX,
        S_TXW,
        S_RELEASE
    } state_e;

    localparam logic [7:0] OP_WR   = 8'h02;
    localparam logic [7:0] OP_RD   = 8'h03;
    localparam logic [7:0] OP_HOLD = 8'h06;
    localparam logic [7:0] OP_RUN  = 8'h07;

    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    localparam int unsigned TMR_W = 17;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dbg_byte_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expire once LIMIT cycles have elapsed.
module dbg_byte_timer #(
    parameter int unsigned W     = 17,
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = en && !clr && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || !en || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_cmd_ctrl.sv
// Host-debug command sequencer: UART byte commands to memory-bus accesses.
// Optional DBG_CMD_ACK_EN: send A5 after WR/HOLD/RUN, EE after abort/unknown.
module dbg_cmd_ctrl
    import dbg_cmd_pkg::*;
#(
    parameter logic [7:0]  CMD_WR      = OP_WR,
    parameter logic [7:0]  CMD_RD      = OP_RD,
    parameter logic [7:0]  CMD_HOLD    = OP_HOLD,
    parameter logic [7:0]  CMD_RUN     = OP_RUN,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        cpu_rst,
    output logic        cpu_pause,
    input  logic        cpu_idle,
    output logic        host_own,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  err_cnt
);

    state_e      state_q, state_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        cpu_pause_q, cpu_pause_d;
    logic        host_own_q, host_own_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        is_wr_q, is_wr_d;
    logic        paused_q, paused_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_inc;
    logic        tmr_en;
    logic        tmr_expire;

    assign tmr_en = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);

    dbg_byte_timer #(
        .W     (TMR_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        cpu_rst_d   = cpu_rst_q;
        cpu_pause_d = cpu_pause_q;
        host_own_d  = host_own_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        is_wr_d     = is_wr_q;
        paused_d    = paused_q;
        byte_d      = byte_q;
        err_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_wr_d = (rx_data == CMD_WR);
                        state_d = S_ADDR_HI;
                    end else if (rx_data == CMD_HOLD) begin
                        cpu_rst_d   = 1'b1;
                        cpu_pause_d = 1'b0;
                        host_own_d  = 1'b1;
`ifdef DBG_CMD_ACK_EN
                        byte_d  = ACK_BYTE;
                        state_d = S_TX;
`endif
                    end else if (rx_data == CMD_RUN) begin
                        cpu_rst_d  = 1'b0;
                        host_own_d = 1'b0;
`ifdef DBG_CMD_ACK_EN
                        byte_d  = ACK_BYTE;
                        state_d = S_TX;
`endif
                    end else begin
                        err_inc = 1'b1;
`ifdef DBG_CMD_ACK_EN
                        byte_d  = NAK_BYTE;
                        state_d = S_TX;
`endif
                    end
                end
            end
            S_ADDR_HI, S_ADDR_LO, S_DATA: begin
                if (rx_valid) begin
                    if (state_q == S_ADDR_HI) begin
                        mem_addr_d[15:8] = rx_data;
                        state_d          = S_ADDR_LO;
                    end else if (state_q == S_ADDR_LO) begin
                        mem_addr_d[7:0] = rx_data;
                        state_d         = is_wr_q ? S_DATA : S_GRAB;
                    end else begin
                        mem_wdata_d = rx_data;
                        state_d     = S_GRAB;
                    end
                end else if (tmr_expire) begin
                    err_inc = 1'b1;
`ifdef DBG_CMD_ACK_EN
                    byte_d  = NAK_BYTE;
                    state_d = S_TX;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_GRAB: begin
                // host_own is already 1 when the CPU is held in reset, or
                // becomes 1 one cycle after a paused CPU reports idle.
                if (host_own_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = is_wr_q;
                    state_d   = S_ACCESS;
                end else begin
                    cpu_pause_d = 1'b1;
                    if (cpu_idle) begin
                        host_own_d = 1'b1;
                        paused_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    byte_d    = mem_rdata;
                    if (!is_wr_q) begin
                        state_d = S_TX;
                    end else begin
`ifdef DBG_CMD_ACK_EN
                        byte_d  = ACK_BYTE;
                        state_d = S_TX;
`else
                        state_d = S_RELEASE;
`endif
                    end
                end
            end
            S_TX: begin
                if (!tx_active) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_q;
                    state_d    = S_TXW;
                end
            end
            S_TXW: begin
                if (tx_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (paused_q) begin
                    host_own_d  = 1'b0;
                    cpu_pause_d = 1'b0;
                    paused_d    = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_valid && (state_q == S_GRAB || state_q == S_ACCESS || state_q == S_TX ||
                         state_q == S_TXW || state_q == S_RELEASE)) begin
            err_inc = 1'b1;
        end

        err_cnt_d = err_inc ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cpu_rst_q   <= 1'b1;
            cpu_pause_q <= 1'b0;
            host_own_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            err_cnt_q   <= '0;
            is_wr_q     <= 1'b0;
            paused_q    <= 1'b0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_pause_q <= cpu_pause_d;
            host_own_q  <= host_own_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            err_cnt_q   <= err_cnt_d;
            is_wr_q     <= is_wr_d;
            paused_q    <= paused_d;
            byte_q      <= byte_d;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign cpu_pause = cpu_pause_q;
    assign host_own  = host_own_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Scoreboard bench for dbg_cmd_ctrl; honours DBG_CMD_ACK_EN when defined.
module tb_dbg_cmd_ctrl;

    localparam int unsigned TO = 200;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        tx_done;
    logic        cpu_rst;
    logic        cpu_pause;
    logic        cpu_idle;
    logic        host_own;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  err_cnt;

    int   checks = 0;
    int   errors = 0;
    bus_t exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_err;
    logic tx_busy = 1'b0;

    always #5 clk = ~clk;

    dbg_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .cpu_rst   (cpu_rst),
        .cpu_pause (cpu_pause),
        .cpu_idle  (cpu_idle),
        .host_own  (host_own),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err_cnt   (err_cnt)
    );

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return (a == 16'hFFFC) ? 8'h5C : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    // Memory responder: ack two cycles after a request is seen.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && !mem_ack) begin
                repeat (2) @(negedge clk);
                mem_rdata = mem_model(mem_addr);
                mem_ack   = 1'b1;
                @(negedge clk);
                mem_ack   = 1'b0;
            end
        end
    end

    // Bus monitor: pops the expected access on each new request.
    initial begin
        logic        req_d;
        logic [15:0] h_addr;
        logic [7:0]  h_wd;
        bus_t        e;
        req_d = 1'b0;
        h_addr = '0;
        h_wd = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && !req_d) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: we=%b addr=%h wdata=%h, required no access",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    e = exp_bus.pop_front();
                    if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL bus_txn: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                    end
                end
                checks++;
                if (host_own !== 1'b1) begin
                    errors++;
                    $display("FAIL bus_owner: host_own=%b, required 1", host_own);
                end
                h_addr = mem_addr;
                h_wd   = mem_wdata;
            end else if (!rst && mem_req && req_d) begin
                checks++;
                if (mem_addr !== h_addr || mem_wdata !== h_wd) begin
                    errors++;
                    $display("FAIL bus_stable: addr=%h wdata=%h, required addr=%h wdata=%h",
                             mem_addr, mem_wdata, h_addr, h_wd);
                end
            end
            req_d = mem_req && !rst;
        end
    end

    // UART TX model: checks each transmitted byte against the expected queue.
    initial begin
        logic [7:0] held;
        logic [7:0] e;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                tx_busy   = 1'b1;
                tx_active = 1'b1;
                held      = tx_data;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: tx_data=%h, required no byte", tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: tx_data=%h, required %h", tx_data, e);
                    end
                end
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (tx_start !== 1'b0 || tx_data !== held) begin
                        errors++;
                        $display("FAIL tx_hold: tx_start=%b tx_data=%h, required 0/%h",
                                 tx_start, tx_data, held);
                    end
                end
                tx_done = 1'b1;
                @(negedge clk);
                tx_done   = 1'b0;
                tx_active = 1'b0;
                tx_busy   = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        exp_bus.push_back(t);
        if (!we) exp_tx.push_back(mem_model(a));
`ifdef DBG_CMD_ACK_EN
        if (we) exp_tx.push_back(8'hA5);
`endif
    endtask

    task automatic push_ack(input logic [7:0] b);
`ifdef DBG_CMD_ACK_EN
        exp_tx.push_back(b);
`else
        if (b == 8'h00) exp_tx.push_back(b);
`endif
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_busy || mem_req) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d bus / %0d tx outstanding, required 0/0",
                     name, exp_bus.size(), exp_tx.size());
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_err(input string name);
        checks++;
        if (err_cnt !== exp_err) begin
            errors++;
            $display("FAIL %s_err_cnt: err_cnt=%h, required %h", name, err_cnt, exp_err);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (cpu_rst !== 1'b1 || host_own !== 1'b1 || cpu_pause !== 1'b0 || mem_req !== 1'b0 ||
            mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0 || tx_start !== 1'b0 ||
            tx_data !== 8'h0 || err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: rst=%b own=%b pause=%b req=%b we=%b addr=%h wd=%h txs=%b txd=%h err=%h, required 1 1 0 0 0 0000 00 0 00 00",
                     cpu_rst, host_own, cpu_pause, mem_req, mem_we, mem_addr, mem_wdata,
                     tx_start, tx_data, err_cnt);
        end
    endtask

    task automatic test_write();
        push_bus(1'b1, 16'h0300, 8'hAB);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'hAB);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_latency1: mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL write_latency2: mem_req=%b, required 1", mem_req);
        end
        wait_drain("write");
        check_err("write");
    endtask

    task automatic test_read();
        push_bus(1'b0, 16'hFFFC, 8'h00);
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'hFC);
        wait_drain("read");
        check_err("read");
        checks++;
        if (cpu_pause !== 1'b0 || host_own !== 1'b1) begin
            errors++;
            $display("FAIL read_held: cpu_pause=%b host_own=%b, required 0/1", cpu_pause, host_own);
        end
    endtask

    task automatic test_pause();
        logic seen_own;
        logic prev_pause;
        logic found;
        cpu_idle = 1'b0;
        push_ack(8'hA5);
        send_byte(8'h07);
        wait_drain("run");
        checks++;
        if (cpu_rst !== 1'b0 || host_own !== 1'b0) begin
            errors++;
            $display("FAIL run_state: cpu_rst=%b host_own=%b, required 0/0", cpu_rst, host_own);
        end
        push_bus(1'b0, 16'h8000, 8'h00);
        send_byte(8'h03);
        send_byte(8'h80);
        send_byte(8'h00);
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL pause_no_req: mem_req=%b, required 0", mem_req);
            end
        end
        checks++;
        if (cpu_pause !== 1'b1 || host_own !== 1'b0) begin
            errors++;
            $display("FAIL pause_req: cpu_pause=%b host_own=%b, required 1/0", cpu_pause, host_own);
        end
        cpu_idle = 1'b1;
        seen_own = 1'b0;
        prev_pause = cpu_pause;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (host_own === 1'b1) seen_own = 1'b1;
            else if (seen_own) found = 1'b1;
            if (!found) prev_pause = cpu_pause;
        end
        checks++;
        if (!found || cpu_pause !== 1'b0 || prev_pause !== 1'b1) begin
            errors++;
            $display("FAIL pause_release: found=%b cpu_pause=%b prev_pause=%b, required 1/0/1",
                     found, cpu_pause, prev_pause);
        end
        wait_drain("pause");
        cpu_idle = 1'b0;
        push_ack(8'hA5);
        send_byte(8'h06);
        wait_drain("hold");
        checks++;
        if (cpu_rst !== 1'b1 || host_own !== 1'b1 || cpu_pause !== 1'b0) begin
            errors++;
            $display("FAIL hold_state: cpu_rst=%b host_own=%b cpu_pause=%b, required 1/1/0",
                     cpu_rst, host_own, cpu_pause);
        end
        check_err("pause");
    endtask

    task automatic test_timeout();
        send_byte(8'h02);
        send_byte(8'h20);
        push_ack(8'hEE);
        repeat (TO - 20) @(negedge clk);
        check_err("timeout_early");
        repeat (40) @(negedge clk);
        exp_err = exp_err + 8'd1;
        check_err("timeout_abort");
        wait_drain("timeout");
        push_bus(1'b1, 16'h2006, 8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h06);
        send_byte(8'h00);
        wait_drain("after_timeout");
        check_err("after_timeout");
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_bus(1'b0, 16'hFFFC, 8'h00);
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'hFC);
        send_byte(8'h99);
        exp_err = 8'h01;
        wait_drain("discard");
        check_err("discard");
        push_bus(1'b1, 16'h0301, 8'h12);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h12);
        wait_drain("b2b_write");
        check_err("b2b_write");
    endtask

    task automatic test_reset_abandon();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        do_reset();
        push_ack(8'hEE);
        send_byte(8'hAB);
        exp_err = 8'h01;
        wait_drain("abandon");
        check_err("abandon");
    endtask

    task automatic test_unknown();
        do_reset();
        push_ack(8'hEE);
        send_byte(8'h55);
        wait_drain("unknown");
        exp_err = 8'h01;
        check_err("unknown_first");
        for (int i = 1; i < 300; i++) begin
            push_ack(8'hEE);
            send_byte(8'h55);
            wait_drain("unknown_loop");
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            if (i == 254) check_err("unknown_reach_ff");
        end
        check_err("unknown_saturate");
    endtask

`ifdef DBG_CMD_ACK_EN
    task automatic test_ack();
        do_reset();
        push_ack(8'hA5);
        send_byte(8'h06);
        wait_drain("ack_hold");
        push_ack(8'hEE);
        send_byte(8'h11);
        wait_drain("ack_nak");
        exp_err = 8'h01;
        check_err("ack_nak");
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        cpu_idle = 1'b0;
        exp_err = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_pause();
        test_timeout();
        test_back_to_back();
        test_reset_abandon();
        test_unknown();
`ifdef DBG_CMD_ACK_EN
        test_ack();
`endif
        checks++;
        if (exp_bus.size() != 0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d bus / %0d tx expected items unseen, required 0/0",
                     exp_bus.size(), exp_tx.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
